apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
Two-requester APB master that shares one APB slave port between requesters via round-robin arbitration. It sequences the IDLE/SETUP/ACCESS protocol, waits for PREADY, and returns read data or error per transfer. A watchdog turns a hung transfer into an error response. It drives PSELx/PENABLE/PWRITE/PADDR/PWDATA into the existing APB slave and consumes its PRDATA/PREADY/PSLVERR.

Parameters:
DW, 32, APB data width
AW, 32, APB address width
TIMEOUT, 16, max ACCESS-phase cycles waiting for PREADY before forced error completion (≥2)

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  reset, asynchronous, active-low
req0_valid  in  1  requester 0 transfer request
req0_write  in  1  1=write, 0=read
req0_addr  in  AW  requester 0 address
req0_wdata  in  DW  requester 0 write data
req0_ready  out  1  one-cycle pulse: requester 0 request accepted
req1_valid / req1_write / req1_addr / req1_wdata / req1_ready  same as requester 0
rsp_valid  out  1  one-cycle completion pulse
rsp_id  out  1  requester that owns rsp_valid
rsp_rdata  out  DW  read data (0 for writes and timeouts)
rsp_err  out  1  PSLVERR captured, or timeout
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  AW  APB address
PWDATA  out  DW  APB write data
PRDATA  in  DW  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (async, PRESETn=0): state IDLE; all outputs 0; rr pointer = 1 (req0 wins first tie); timeout counter 0. Reset mid-transfer drops the transfer silently, no rsp_valid.
- States: IDLE, SETUP, ACCESS; all APB outputs are registered.
- IDLE: if any reqN_valid, grant and go to SETUP next edge; reqN_ready=1 for exactly that one cycle (the grant cycle); latch write/addr/wdata/id. PSELx=0.
- Arbitration: one valid wins; both valid → grant the one not last granted; pointer updates on each grant.
- SETUP (exactly 1 cycle): PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA from latch → ACCESS.
- ACCESS: PSELx=1, PENABLE=1, signals stable. Counter increments each ACCESS cycle with PREADY=0.
  - PREADY=1: transfer completes that edge. Next cycle: rsp_valid=1, rsp_id=latched id, rsp_rdata=PRDATA if read else 0, rsp_err=PSLVERR.
  - Counter reaches TIMEOUT-1 with PREADY=0: forced completion; rsp_err=1, rsp_rdata=0.
  - On completion, if any reqN_valid is sampled that same cycle: arbitrate, pulse reqN_ready, go directly to SETUP (back-to-back, PSELx stays 1, PENABLE drops). Else IDLE, PSELx=0, PENABLE=0.
- Requesters hold valid and fields stable until ready; a request must not change after valid. Valid without ready is not a transfer.
- rsp_valid never asserts twice for one transfer. At most one outstanding transfer.
- Latency: grant → SETUP 1 cycle → ACCESS ≥1 cycle → rsp_valid 1 cycle after the PREADY edge. Zero-wait write: rsp_valid 3 cycles after grant.
- Counter clears on entry to SETUP.

Decomposition:
- Shared package apb_pkg: state encoding (IDLE/SETUP/ACCESS), DW/AW defaults, TIMEOUT default.
- One sub-module: apb_rr_arb2 (2-way round-robin arbiter: valid[1:0], advance → grant one-hot, id). The FSM, latches, watchdog, and response registers stay in the top level.

Test Plan:
- Reset: hold PRESETn=0 for 3 cycles mid-ACCESS → all outputs 0, no rsp_valid after release, state IDLE.
- Single write, req0 addr=0x0000_0010 wdata=0xDEAD_BEEF, slave PREADY in first ACCESS → PSELx 2 cycles, PENABLE 1 cycle, rsp_valid id=0 err=0 rdata=0.
- Read from a slave with 2 wait cycles returning 0x1234_5678 → ACCESS lasts 3 cycles, PADDR stable throughout, rsp_rdata=0x1234_5678 id=1.
- Both requesters valid continuously, 4 transfers → grant order 0,1,0,1; back-to-back SETUP with no IDLE cycle; PENABLE low in each SETUP.
- PREADY held 0 with TIMEOUT=16 → completion after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSELx deasserts.
- PSLVERR=1 with PREADY on a write → rsp_err=1; next transfer proceeds normally with err=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB master: state encoding and parameter defaults.
package apb_pkg;

   localparam int unsigned DW_DEF      = 32;
   localparam int unsigned AW_DEF      = 32;
   localparam int unsigned TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module apb_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant_c,
   output logic       id_c
);

   logic last_q;

   always_comb begin
      id_c    = 1'b0;
      grant_c = 2'b00;
      if (valid == 2'b11) begin
         id_c = ~last_q;
      end else begin
         id_c = valid[1];
      end
      if (|valid) begin
         grant_c = id_c ? 2'b10 : 2'b01;
      end
   end

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (advance && (|valid)) begin
         last_q <= id_c;
      end
   end

endmodule : apb_rr_arb2

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters: round-robin grant, SETUP/ACCESS sequencing, watchdog.
module apb_master_arb
   import apb_pkg::*;
#(
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          req0_valid,
   input  logic          req0_write,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic          req1_write,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_ready,
   output logic          rsp_valid,
   output logic          rsp_id,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          PSELx,
   output logic          PENABLE,
   output logic          PWRITE,
   output logic [AW-1:0] PADDR,
   output logic [DW-1:0] PWDATA,
   input  logic [DW-1:0] PRDATA,
   input  logic          PREADY,
   input  logic          PSLVERR
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   apb_state_e    state_q, state_d;
   logic          psel_q, psel_d;
   logic          penable_q, penable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          write_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          id_q;
   logic          rsp_valid_q;
   logic          rsp_id_q;
   logic [DW-1:0] rsp_rdata_q;
   logic          rsp_err_q;

   logic [1:0]    valid;
   logic [1:0]    gnt;
   logic          gnt_id;
   logic          accept;
   logic          done;
   logic          timeout_hit;

   assign valid = {req1_valid, req0_valid};

   apb_rr_arb2 u_arb (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .valid   (valid),
      .advance (accept),
      .grant_c (gnt),
      .id_c    (gnt_id)
   );

   // Next-state, next APB control and watchdog counter.
   always_comb begin
      state_d     = state_q;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      done        = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|valid) begin
               accept  = 1'b1;
               psel_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            timeout_hit = !PREADY && (cnt_q == CW'(TIMEOUT - 1));
            if (PREADY || timeout_hit) begin
               done = 1'b1;
               // Back-to-back: a waiting request skips IDLE and goes straight to SETUP.
               if (|valid) begin
                  accept  = 1'b1;
                  psel_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_SETUP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               psel_d    = 1'b1;
               penable_d = 1'b1;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered APB outputs, request latch and response capture.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= done;
         if (accept) begin
            write_q <= gnt_id ? req1_write : req0_write;
            addr_q  <= gnt_id ? req1_addr  : req0_addr;
            wdata_q <= gnt_id ? req1_wdata : req0_wdata;
            id_q    <= gnt_id;
         end
         if (done) begin
            rsp_id_q    <= id_q;
            rsp_err_q   <= timeout_hit | PSLVERR;
            rsp_rdata_q <= (timeout_hit || write_q) ? '0 : PRDATA;
         end
      end
   end

   assign req0_ready = accept & gnt[0];
   assign req1_ready = accept & gnt[1];
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign PSELx      = psel_q;
   assign PENABLE    = penable_q;
   assign PWRITE     = write_q;
   assign PADDR      = addr_q;
   assign PWDATA     = wdata_q;

endmodule : apb_master_arb

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: the bench plays both requesters and the APB slave.
module tb_apb_master_arb;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        req0_valid, req0_write, req0_ready;
   logic [31:0] req0_addr, req0_wdata;
   logic        req1_valid, req1_write, req1_ready;
   logic [31:0] req1_addr, req1_wdata;
   logic        rsp_valid, rsp_id, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSELx, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;

   int passed = 0;
   int total  = 0;

   always #5 PCLK = ~PCLK;

   apb_master_arb dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .req0_valid (req0_valid),
      .req0_write (req0_write),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_write (req1_write),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .PSELx      (PSELx),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs change 2 time units after the edge.
   task automatic cyc();
      @(posedge PCLK);
      #2;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".psel"},    64'(PSELx),     64'h0);
      check({tag, ".penable"}, 64'(PENABLE),   64'h0);
      check({tag, ".rspv"},    64'(rsp_valid), 64'h0);
      check({tag, ".rdy0"},    64'(req0_ready), 64'h0);
      check({tag, ".rdy1"},    64'(req1_ready), 64'h0);
   endtask

   task automatic check_rsp(input string tag, input logic id, input logic [31:0] rdata,
                            input logic err);
      check({tag, ".rspv"},  64'(rsp_valid), 64'h1);
      check({tag, ".id"},    64'(rsp_id),    64'(id));
      check({tag, ".rdata"}, 64'(rsp_rdata), 64'(rdata));
      check({tag, ".err"},   64'(rsp_err),   64'(err));
   endtask

   initial begin
      PRESETn = 1'b0;
      req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

      repeat (3) cyc();
      #1;
      check_idle_outputs("rst0");
      check("rst0.paddr", 64'(PADDR), 64'h0);
      PRESETn = 1'b1;

      // Single zero-wait write from requester 0
      cyc();
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h0000_0010; req0_wdata = 32'hDEAD_BEEF;
      PREADY = 1'b1;
      #1;
      check("wr.grant.rdy0", 64'(req0_ready), 64'h1);
      check("wr.grant.rdy1", 64'(req1_ready), 64'h0);
      check("wr.grant.psel", 64'(PSELx), 64'h0);
      cyc();
      req0_valid = 1'b0;
      #1;
      check("wr.setup.psel",  64'(PSELx),   64'h1);
      check("wr.setup.pen",   64'(PENABLE), 64'h0);
      check("wr.setup.pwr",   64'(PWRITE),  64'h1);
      check("wr.setup.paddr", 64'(PADDR),   64'h10);
      check("wr.setup.pwd",   64'(PWDATA),  64'hDEAD_BEEF);
      cyc(); #1;
      check("wr.acc.psel", 64'(PSELx),     64'h1);
      check("wr.acc.pen",  64'(PENABLE),   64'h1);
      check("wr.acc.rspv", 64'(rsp_valid), 64'h0);
      cyc(); #1;
      check_rsp("wr.rsp", 1'b0, 32'h0, 1'b0);
      check("wr.rsp.psel", 64'(PSELx),   64'h0);
      check("wr.rsp.pen",  64'(PENABLE), 64'h0);
      cyc(); #1;
      check("wr.after.rspv", 64'(rsp_valid), 64'h0);

      // Read from requester 1 with two wait cycles
      PREADY = 1'b0;
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h0000_0020;
      #1;
      check("rd.grant.rdy1", 64'(req1_ready), 64'h1);
      cyc();
      req1_valid = 1'b0;
      #1;
      check("rd.setup.pwr",   64'(PWRITE), 64'h0);
      check("rd.setup.paddr", 64'(PADDR),  64'h20);
      cyc(); #1;
      check("rd.acc1.pen",   64'(PENABLE), 64'h1);
      cyc(); #1;
      check("rd.acc2.pen",   64'(PENABLE), 64'h1);
      check("rd.acc2.paddr", 64'(PADDR),   64'h20);
      cyc();
      PREADY = 1'b1; PRDATA = 32'h1234_5678;
      #1;
      check("rd.acc3.pen",   64'(PENABLE),   64'h1);
      check("rd.acc3.paddr", 64'(PADDR),     64'h20);
      check("rd.acc3.rspv",  64'(rsp_valid), 64'h0);
      cyc();
      PRDATA = 32'h0;
      #1;
      check_rsp("rd.rsp", 1'b1, 32'h1234_5678, 1'b0);
      check("rd.rsp.psel", 64'(PSELx), 64'h0);

      // Both requesters continuously valid: order 0,1,0,1 with no IDLE gap
      cyc();
      PREADY = 1'b1;
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h100; req0_wdata = 32'hA0;
      req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h200; req1_wdata = 32'hB0;
      #1;
      check("bb.c0.rdy0", 64'(req0_ready), 64'h1);
      check("bb.c0.rdy1", 64'(req1_ready), 64'h0);
      cyc();
      req0_addr = 32'h104; req0_wdata = 32'hA1;
      #1;
      check("bb.c1.pen",   64'(PENABLE), 64'h0);
      check("bb.c1.paddr", 64'(PADDR),   64'h100);
      cyc(); #1;
      check("bb.c2.rdy1", 64'(req1_ready), 64'h1);
      check("bb.c2.rdy0", 64'(req0_ready), 64'h0);
      cyc();
      req1_addr = 32'h204; req1_wdata = 32'hB1;
      #1;
      check("bb.c3.psel",  64'(PSELx),   64'h1);
      check("bb.c3.pen",   64'(PENABLE), 64'h0);
      check("bb.c3.paddr", 64'(PADDR),   64'h200);
      check_rsp("bb.c3", 1'b0, 32'h0, 1'b0);
      cyc(); #1;
      check("bb.c4.rdy0", 64'(req0_ready), 64'h1);
      check("bb.c4.rdy1", 64'(req1_ready), 64'h0);
      cyc();
      req0_valid = 1'b0;
      #1;
      check("bb.c5.pen",   64'(PENABLE), 64'h0);
      check("bb.c5.paddr", 64'(PADDR),   64'h104);
      check("bb.c5.pwd",   64'(PWDATA),  64'hA1);
      check_rsp("bb.c5", 1'b1, 32'h0, 1'b0);
      cyc(); #1;
      check("bb.c6.rdy1", 64'(req1_ready), 64'h1);
      cyc();
      req1_valid = 1'b0;
      #1;
      check("bb.c7.pen",   64'(PENABLE), 64'h0);
      check("bb.c7.paddr", 64'(PADDR),   64'h204);
      check_rsp("bb.c7", 1'b0, 32'h0, 1'b0);
      cyc(); #1;
      check("bb.c8.pen",  64'(PENABLE),    64'h1);
      check("bb.c8.rdy0", 64'(req0_ready), 64'h0);
      cyc(); #1;
      check("bb.c9.psel", 64'(PSELx), 64'h0);
      check_rsp("bb.c9", 1'b1, 32'h0, 1'b0);

      // Hung slave: watchdog completes after 16 ACCESS cycles
      cyc();
      PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h300;
      #1;
      check("to.grant.rdy0", 64'(req0_ready), 64'h1);
      cyc();
      req0_valid = 1'b0;
      cyc(); #1;
      for (int i = 1; i < 16; i++) begin
         check($sformatf("to.acc%0d.pen", i), 64'(PENABLE), 64'h1);
         check($sformatf("to.acc%0d.rspv", i), 64'(rsp_valid), 64'h0);
         cyc(); #1;
      end
      check("to.acc16.pen", 64'(PENABLE), 64'h1);
      cyc(); #1;
      check_rsp("to.rsp", 1'b0, 32'h0, 1'b1);
      check("to.rsp.psel", 64'(PSELx), 64'h0);
      PRDATA = 32'h0;

      // Slave error on a write, then a clean write
      cyc();
      PREADY = 1'b1; PSLVERR = 1'b1;
      req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h400; req1_wdata = 32'h55;
      #1;
      check("se.grant.rdy1", 64'(req1_ready), 64'h1);
      cyc();
      req1_valid = 1'b0;
      cyc();
      cyc(); #1;
      check_rsp("se.rsp", 1'b1, 32'h0, 1'b1);
      PSLVERR = 1'b0;
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h500; req0_wdata = 32'h66;
      #1;
      check("ok.grant.rdy0", 64'(req0_ready), 64'h1);
      cyc();
      req0_valid = 1'b0;
      cyc();
      cyc(); #1;
      check_rsp("ok.rsp", 1'b0, 32'h0, 1'b0);

      // Reset asserted mid-ACCESS drops the transfer silently
      cyc();
      PREADY = 1'b0;
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h600;
      cyc();
      req1_valid = 1'b0;
      cyc(); #1;
      check("mr.acc.pen", 64'(PENABLE), 64'h1);
      PRESETn = 1'b0;
      #1;
      check_idle_outputs("mr.async");
      check("mr.async.paddr", 64'(PADDR), 64'h0);
      repeat (3) cyc();
      PREADY = 1'b1;
      #1;
      check_idle_outputs("mr.held");
      PRESETn = 1'b1;
      cyc(); #1;
      check_idle_outputs("mr.rel1");
      cyc(); #1;
      check_idle_outputs("mr.rel2");

      // Pointer back at reset value: requester 0 wins the first tie
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h700;
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h800;
      PRDATA = 32'hCAFE_0001;
      #1;
      check("pt.rdy0", 64'(req0_ready), 64'h1);
      check("pt.rdy1", 64'(req1_ready), 64'h0);
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      check("pt.setup.paddr", 64'(PADDR), 64'h700);
      cyc();
      cyc(); #1;
      check_rsp("pt.rsp", 1'b0, 32'hCAFE_0001, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_apb_master_arb
